// File: rtl/anubis_round_ctrl.sv
// Iterative round sequencer for the Anubis 128-bit cipher core.
// Holds the cipher state, fetches round keys K0..KR and applies sigma (key addition) per round.

module anubis_sigma (
    input  logic [127:0] sel_i,
    input  logic [127:0] key_i,
    output logic [127:0] sum_o
);
    assign sum_o = sel_i ^ key_i;
endmodule

module anubis_round_ctrl #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] data_in,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out,
    output logic         key_req,
    output logic [4:0]   key_idx,
    input  logic         key_ack,
    input  logic [127:0] round_key,
    output logic [127:0] rf_in,
    input  logic [127:0] rf_out,
    output logic         last_round
);

    if (N < 4 || N > 10) begin : g_bad_n
        $error("anubis_round_ctrl: N must be in 4..10");
    end

    localparam logic [4:0] R_IDX = 5'(8 + N);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_KWAIT = 2'd1,
        S_DONE  = 2'd2
    } fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [4:0]   r_q, r_d;
    logic [127:0] state_q, state_d;
    logic [127:0] data_out_q, data_out_d;
    logic         done_q, done_d;

    logic         accept;
    logic         last_key;
    logic [127:0] sigma_sel;
    logic [127:0] key_sum;

    // done_q blocks acceptance so a start coinciding with the done pulse is dropped.
    assign accept   = (fsm_q == S_IDLE) && start && !done_q;
    assign last_key = (r_q == R_IDX);

    // At r==0 the state still holds data_in, so K0 is added to the input block.
    assign sigma_sel = (r_q == 5'd0) ? state_q : rf_out;

    anubis_sigma u_sigma (
        .sel_i (sigma_sel),
        .key_i (round_key),
        .sum_o (key_sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= S_IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fsm_d = fsm_q;
        unique case (fsm_q)
            S_IDLE:  if (accept) fsm_d = S_KWAIT;
            S_KWAIT: if (key_ack && last_key) fsm_d = S_DONE;
            S_DONE:  fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;
        unique case (fsm_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = data_in;
                    r_d     = 5'd0;
                end
            end
            S_KWAIT: begin
                if (key_ack) begin
                    state_d = key_sum;
                    if (!last_key) r_d = r_q + 5'd1;
                end
            end
            S_DONE: begin
                data_out_d = state_q;
                done_d     = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: the 128-bit data registers are reset too, so an aborted block never leaks out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q        <= 5'd0;
            state_q    <= '0;
            data_out_q <= '0;
            done_q     <= 1'b0;
        end else begin
            r_q        <= r_d;
            state_q    <= state_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        busy       = (fsm_q != S_IDLE) || done_q;
        key_req    = (fsm_q == S_KWAIT);
        key_idx    = (fsm_q == S_KWAIT) ? r_q : 5'd0;
        last_round = (fsm_q == S_KWAIT) && last_key;
        done       = done_q;
        data_out   = data_out_q;
        rf_in      = state_q;
    end

endmodule

// File: tb/tb_anubis_round_ctrl.sv
// Directed bench for anubis_round_ctrl: N=4 and N=10 instances, identity and inverting
// round functions, key_ack stalls, ignored starts, mid-operation reset.

module tb_anubis_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, key_ack;
    logic [127:0] data_in;
    logic         inv_mode, rand_key, sel10;
    logic [127:0] key_tab [0:18];

    logic         busy4, done4, key_req4, last4;
    logic [4:0]   idx4;
    logic [127:0] dout4, rfin4, rfout4, rk4;
    logic         busy10, done10, key_req10, last10;
    logic [4:0]   idx10;
    logic [127:0] dout10, rfin10, rfout10, rk10;

    assign rfout4  = inv_mode ? ~rfin4 : rfin4;
    assign rk4     = rand_key ? key_tab[idx4] : {123'b0, idx4};
    assign rfout10 = inv_mode ? ~rfin10 : rfin10;
    assign rk10    = rand_key ? key_tab[idx10] : {123'b0, idx10};

    anubis_round_ctrl #(.N(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .busy(busy4), .done(done4), .data_out(dout4),
        .key_req(key_req4), .key_idx(idx4), .key_ack(key_ack), .round_key(rk4),
        .rf_in(rfin4), .rf_out(rfout4), .last_round(last4)
    );

    anubis_round_ctrl #(.N(10)) dut10 (
        .clk(clk), .rst_n(rst_n), .start(start), .data_in(data_in),
        .busy(busy10), .done(done10), .data_out(dout10),
        .key_req(key_req10), .key_idx(idx10), .key_ack(key_ack), .round_key(rk10),
        .rf_in(rfin10), .rf_out(rfout10), .last_round(last10)
    );

    logic         mon_busy, mon_done, mon_key_req, mon_last;
    logic [4:0]   mon_idx;
    logic [127:0] mon_dout, mon_rfin;

    assign mon_busy    = sel10 ? busy10    : busy4;
    assign mon_done    = sel10 ? done10    : done4;
    assign mon_key_req = sel10 ? key_req10 : key_req4;
    assign mon_last    = sel10 ? last10    : last4;
    assign mon_idx     = sel10 ? idx10     : idx4;
    assign mon_dout    = sel10 ? dout10    : dout4;
    assign mon_rfin    = sel10 ? rfin10    : rfin4;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after a rising edge; that cycle is cycle 0 (start asserted).
    task automatic run_op(input int stall, input bit extra_start, input int rst_at,
                          output int lat, output logic [127:0] res, output int n_last,
                          output logic [4:0] last_idx, output int idx_moves,
                          output logic [127:0] after_k0);
        int         stall_cnt;
        logic [4:0] held;
        stall_cnt = 0;
        held      = '0;
        res       = '0;
        n_last    = 0;
        last_idx  = '0;
        idx_moves = 0;
        after_k0  = '0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat   = 1;
        while (lat < 200) begin
            if (lat == rst_at) begin
                rst_n = 1'b0;
                #1;
                return;
            end
            if (mon_done) begin
                res = mon_dout;
                if (extra_start) start = 1'b1;
                break;
            end
            start = extra_start && (lat == 5);
            if (lat == 2) after_k0 = mon_rfin;
            if (mon_last) begin
                n_last++;
                last_idx = mon_idx;
            end
            if (mon_key_req) begin
                if (stall_cnt > 0 && mon_idx !== held) idx_moves++;
                if (stall_cnt < stall) begin
                    if (stall_cnt == 0) held = mon_idx;
                    key_ack = 1'b0;
                    stall_cnt++;
                end else begin
                    key_ack   = 1'b1;
                    stall_cnt = 0;
                end
            end else begin
                key_ack = 1'b1;
            end
            @(posedge clk); #1;
            lat++;
        end
    endtask

    int           lat, n_last, idx_moves;
    logic [127:0] res, after_k0, ref_s, a5;
    logic [4:0]   last_idx;

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        key_ack  = 1'b1;
        data_in  = '0;
        inv_mode = 1'b0;
        rand_key = 1'b0;
        sel10    = 1'b0;
        a5       = {16{8'hA5}};
        for (int i = 0; i < 19; i++) key_tab[i] = '0;

        #12;
        check("rst_busy",     128'(busy4),    128'd0);
        check("rst_done",     128'(done4),    128'd0);
        check("rst_key_req",  128'(key_req4), 128'd0);
        check("rst_last",     128'(last4),    128'd0);
        check("rst_key_idx",  128'(idx4),     128'd0);
        check("rst_data_out", dout4,          128'd0);
        check("rst_rf_in",    rfin4,          128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Identity round function, K[r]=r, N=4: XOR of 0..12 is 0xC.
        data_in = a5;
        run_op(0, 1'b0, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("n4_latency",  128'(lat),      128'd15);
        check("n4_result",   res,            a5 ^ 128'hC);
        check("n4_last_cnt", 128'(n_last),   128'd1);
        check("n4_last_idx", 128'(last_idx), 128'd12);
        idle(40);

        // N=10: XOR of 0..18 is 0x13.
        sel10 = 1'b1;
        run_op(0, 1'b0, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("n10_latency",  128'(lat),      128'd21);
        check("n10_result",   res,            a5 ^ 128'h13);
        check("n10_last_cnt", 128'(n_last),   128'd1);
        check("n10_last_idx", 128'(last_idx), 128'd18);
        sel10 = 1'b0;
        idle(40);

        // Three stall cycles before every key: 13 keys * 3 = 39 extra cycles.
        run_op(3, 1'b0, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("stall_latency",   128'(lat),       128'd54);
        check("stall_result",    res,             a5 ^ 128'hC);
        check("stall_idx_moves", 128'(idx_moves), 128'd0);
        idle(40);

        // Starts at cycles 5 and 15 must be dropped; start at 16 is accepted.
        run_op(0, 1'b1, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("restart_latency", 128'(lat), 128'd15);
        check("restart_result",  res,       a5 ^ 128'hC);
        @(posedge clk); #1;
        check("restart_c16_busy", 128'(busy4), 128'd0);
        check("restart_c16_done", 128'(done4), 128'd0);
        data_in = ~a5;
        run_op(0, 1'b0, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("c16_start_latency", 128'(lat), 128'd15);
        check("c16_start_result",  res,       ~a5 ^ 128'hC);
        idle(40);

        // Asynchronous reset at cycle 7 discards the block and clears data_out.
        data_in = a5;
        run_op(0, 1'b0, 7, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("midrst_busy",     128'(busy4),    128'd0);
        check("midrst_key_req",  128'(key_req4), 128'd0);
        check("midrst_data_out", dout4,          128'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(0, 1'b0, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
        check("postrst_latency", 128'(lat), 128'd15);
        check("postrst_result",  res,       a5 ^ 128'hC);
        idle(40);

        // Inverting round function with random data and keys against a reference model.
        inv_mode = 1'b1;
        rand_key = 1'b1;
        for (int t = 0; t < 100; t++) begin
            data_in = {$urandom(), $urandom(), $urandom(), $urandom()};
            for (int i = 0; i < 19; i++)
                key_tab[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
            ref_s = data_in ^ key_tab[0];
            for (int r = 1; r <= 12; r++) ref_s = ~ref_s ^ key_tab[r];
            run_op(0, 1'b0, -1, lat, res, n_last, last_idx, idx_moves, after_k0);
            check("rand_k0_on_data_in", after_k0, data_in ^ key_tab[0]);
            check("rand_result",        res,      ref_s);
            idle(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
